// File: rtl/tb_irq_stim_gen.sv
// Interrupt stimulus generator: watches the commit stream and drives the
// ext/sft/tmr IRQ force lines with pseudo-random gaps, holding each line
// until its handler-ack PC commits.
module tb_irq_stim_gen #(
  parameter int unsigned      PC_W       = 32,
  parameter logic [PC_W-1:0]  ARM_PC     = 'h8000015C,
  parameter logic [PC_W-1:0]  EXT_ACK_PC = 'h800000A6,
  parameter logic [PC_W-1:0]  SFT_ACK_PC = 'h800000BE,
  parameter logic [PC_W-1:0]  TMR_ACK_PC = 'h800000D6,
  parameter logic [PC_W-1:0]  TOHOST_PC  = 'h80000086,
  parameter int unsigned      STOP_CNT   = 32,
  parameter int unsigned      MAX_GAP    = 1000,
  parameter logic [31:0]      SEED       = 32'h1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  output logic            ext_irq,
  output logic            sft_irq,
  output logic            tmr_irq,
  output logic            armed,
  output logic            done,
  output logic [31:0]     tohost_cnt
);

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_WAIT,
    CH_ASSERT,
    CH_STOPPED
  } ch_state_e;

  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [10:0] MG        = 11'(MAX_GAP);

  logic [31:0] lfsr_q, lfsr_d;
  logic        armed_q, armed_d;
  logic [31:0] tohost_q, tohost_d;
  logic        done_q, done_d;
  logic [2:0]  irq_q, irq_d;
  ch_state_e   st_q  [3];
  ch_state_e   st_d  [3];
  logic [10:0] cnt_q [3];
  logic [10:0] cnt_d [3];

  logic        arm_hit, tohost_hit, arm_evt, stop;
  logic [2:0]  ack_hit;

  // Gap folds the 10-bit slice into 1..MAX_GAP.
  function automatic logic [10:0] gap_of(input logic [9:0] s);
    logic [10:0] sx;
    sx = {1'b0, s};
    return 11'd1 + ((sx >= MG) ? (sx - MG) : sx);
  endfunction

  // Commit-stream decode.
  always_comb begin
    arm_hit    = cmt_valid && (cmt_pc == ARM_PC);
    tohost_hit = cmt_valid && (cmt_pc == TOHOST_PC);
    ack_hit[0] = cmt_valid && (cmt_pc == EXT_ACK_PC);
    ack_hit[1] = cmt_valid && (cmt_pc == SFT_ACK_PC);
    ack_hit[2] = cmt_valid && (cmt_pc == TMR_ACK_PC);
    stop       = (tohost_q > STOP_CNT);
    arm_evt    = en && !armed_q && arm_hit;
  end

  // Global state: arm flag, LFSR, tohost counter.
  always_comb begin
    armed_d  = en && (armed_q || arm_hit);
    lfsr_d   = lfsr_q;
    if (armed_q && en) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
    tohost_d = tohost_q;
    if (tohost_hit && (tohost_q != '1)) begin
      tohost_d = tohost_q + 32'd1;
    end
  end

  // Per-channel next state; STOPPED is sticky even across en=0.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      irq_d[i] = irq_q[i];
      if (!en) begin
        irq_d[i] = 1'b0;
        if (st_q[i] != CH_STOPPED) begin
          st_d[i] = CH_IDLE;
        end
      end else begin
        case (st_q[i])
          CH_IDLE: begin
            if (arm_evt) begin
              st_d[i]  = CH_WAIT;
              cnt_d[i] = gap_of(lfsr_q[10*i +: 10]);
            end
          end
          CH_WAIT: begin
            if (cnt_q[i] == 11'd1) begin
              st_d[i]  = CH_ASSERT;
              irq_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 11'd1;
            end
          end
          CH_ASSERT: begin
            if (ack_hit[i]) begin
              irq_d[i] = 1'b0;
              if (stop) begin
                st_d[i] = CH_STOPPED;
              end else begin
                st_d[i]  = CH_WAIT;
                cnt_d[i] = gap_of(lfsr_q[10*i +: 10]);
              end
            end
          end
          default: begin
            irq_d[i] = 1'b0;
          end
        endcase
      end
    end
    done_d = (st_d[0] == CH_STOPPED) && (st_d[1] == CH_STOPPED) &&
             (st_d[2] == CH_STOPPED);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= LFSR_INIT;
      armed_q  <= 1'b0;
      tohost_q <= '0;
      done_q   <= 1'b0;
      irq_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        st_q[i]  <= CH_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      lfsr_q   <= lfsr_d;
      armed_q  <= armed_d;
      tohost_q <= tohost_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      for (int unsigned i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ext_irq    = irq_q[0];
  assign sft_irq    = irq_q[1];
  assign tmr_irq    = irq_q[2];
  assign armed      = armed_q;
  assign done       = done_q;
  assign tohost_cnt = tohost_q;

endmodule
